// File: rtl/viterbi_pkg.sv
// -----------------------------------------------------------------------------
// viterbi_pkg
// Shared constants and helpers for the rate-1/2, K=3 (g = 7,5 octal)
// hard-decision Viterbi decoder.
//
//   NUM_STATES   number of trellis states (2^(K-1))
//   K            constraint length
//   G0 / G1      generator taps applied to {b, s1, s2}; G0 yields c1, G1 yields c0
//   expected_sym branch code emitted on the transition pred -> ns
//   hamming2     Hamming distance between two 2-bit symbols (0..2)
// -----------------------------------------------------------------------------
package viterbi_pkg;

  localparam int NUM_STATES = 4;
  localparam int K          = 3;

  localparam logic [K-1:0] G0 = 3'b111;
  localparam logic [K-1:0] G1 = 3'b101;

  // State s = {s1, s2}. Entering ns means the input bit was ns[1], and the
  // encoder shift register held {b, s1, s2} = {ns[1], pred[1], pred[0]}.
  function automatic logic [1:0] expected_sym(input logic [1:0] ns,
                                              input logic [1:0] pred);
    logic [K-1:0] sr;
    sr = {ns[1], pred[1], pred[0]};
    return {^(sr & G0), ^(sr & G1)};
  endfunction

  function automatic logic [1:0] hamming2(input logic [1:0] a,
                                          input logic [1:0] b);
    logic [1:0] diff;
    diff = a ^ b;
    return {1'b0, diff[1]} + {1'b0, diff[0]};
  endfunction

endpackage

// File: rtl/viterbi_acs.sv
// -----------------------------------------------------------------------------
// viterbi_acs
// Add-compare-select for one trellis state.
//
//   i_pm0 / i_pm1   path metrics of predecessors p0 and p1
//   i_bm0 / i_bm1   branch metrics for the p0 -> ns and p1 -> ns transitions
//   o_pm            surviving (minimum) candidate metric
//   o_sel           1 when p1 survives; ties resolve to p0
// -----------------------------------------------------------------------------
module viterbi_acs #(
  parameter int PM_W = 6
) (
  input  logic [PM_W-1:0] i_pm0,
  input  logic [PM_W-1:0] i_pm1,
  input  logic [1:0]      i_bm0,
  input  logic [1:0]      i_bm1,
  output logic [PM_W-1:0] o_pm,
  output logic            o_sel
);

  logic [PM_W-1:0] w_sum0;
  logic [PM_W-1:0] w_sum1;

  // Metrics are kept bounded by normalisation in the parent, so these sums
  // never wrap.
  assign w_sum0 = i_pm0 + PM_W'(i_bm0);
  assign w_sum1 = i_pm1 + PM_W'(i_bm1);

  // Strict less-than: p0 keeps the path on an equal metric.
  assign o_sel = (w_sum1 < w_sum0);
  assign o_pm  = o_sel ? w_sum1 : w_sum0;

endmodule

// File: rtl/viterbi_decoder.sv
// -----------------------------------------------------------------------------
// viterbi_decoder
// Hard-decision Viterbi decoder for the rate-1/2, K=3 (7,5) convolutional code.
// One symbol per clock, register-exchange survivor memory, fixed decision
// depth TB_DEPTH.
//
// Ports
//   clk       rising-edge clock
//   reset     asynchronous, active-low reset
//   c_in      received code symbol {c1, c0}
//   c_valid   symbol accepted on the clk edge where this is high
//   b_out     decoded bit (holds between pulses)
//   b_valid   one-cycle pulse marking b_out valid
//   best_pm   metric of the best state after the last accepted symbol
//
// Input handshake: there is no ready; the decoder accepts a symbol on every
// rising edge where c_valid is high. With c_valid low all metrics, survivors
// and the symbol counter hold, and b_valid is low on the following cycle.
//
// Output timing: the edge accepting symbol k (0-based) with k >= TB_DEPTH-1
// raises b_valid and presents decoded bit k-TB_DEPTH+1 on b_out.
// -----------------------------------------------------------------------------
module viterbi_decoder
  import viterbi_pkg::*;
#(
  parameter int TB_DEPTH = 15,
  parameter int PM_W     = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      c_in,
  input  logic            c_valid,
  output logic            b_out,
  output logic            b_valid,
  output logic [PM_W-1:0] best_pm
);

  localparam int                CNT_W   = $clog2(TB_DEPTH + 1);
  localparam logic [CNT_W-1:0]  CNT_SAT = CNT_W'(TB_DEPTH);
  localparam logic [CNT_W-1:0]  CNT_OUT = CNT_W'(TB_DEPTH - 1);
  localparam logic [PM_W-1:0]   PM_INIT = PM_W'(1) << (PM_W - 2);

  // Only TB_DEPTH-1 survivor bits are stored: the oldest bit of the updated
  // survivor is consumed by b_out on the same edge and would never be read
  // back from a register.
  logic [NUM_STATES-1:0][PM_W-1:0]     r_pm;
  logic [NUM_STATES-1:0][TB_DEPTH-2:0] r_surv;
  logic [CNT_W-1:0]                    r_cnt;

  logic [NUM_STATES-1:0][PM_W-1:0]     w_pm_acs;
  logic [NUM_STATES-1:0][PM_W-1:0]     w_pm_norm;
  logic [NUM_STATES-1:0][TB_DEPTH-1:0] w_surv_full;
  logic [NUM_STATES-1:0]               w_sel;
  logic [NUM_STATES-1:0]               w_msb;
  logic                                w_all_msb;
  logic [1:0]                          w_lo;
  logic [1:0]                          w_hi;
  logic [1:0]                          w_best;

  // ---------------------------------------------------------------------------
  // Per-state branch metrics, ACS and survivor selection
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < NUM_STATES; g++) begin : g_state
    localparam logic [1:0] NS = 2'(g);
    localparam logic [1:0] P0 = {NS[0], 1'b0};
    localparam logic [1:0] P1 = {NS[0], 1'b1};

    logic [1:0]          w_bm0;
    logic [1:0]          w_bm1;
    logic [TB_DEPTH-2:0] w_surv_win;

    assign w_bm0 = hamming2(c_in, expected_sym(NS, P0));
    assign w_bm1 = hamming2(c_in, expected_sym(NS, P1));

    viterbi_acs #(
      .PM_W (PM_W)
    ) u_acs (
      .i_pm0 (r_pm[P0]),
      .i_pm1 (r_pm[P1]),
      .i_bm0 (w_bm0),
      .i_bm1 (w_bm1),
      .o_pm  (w_pm_acs[g]),
      .o_sel (w_sel[g])
    );

    // The decided bit for entering ns is ns[1]; it becomes the newest (LSB).
    assign w_surv_win     = w_sel[g] ? r_surv[P1] : r_surv[P0];
    assign w_surv_full[g] = {w_surv_win, NS[1]};
    assign w_msb[g]       = w_pm_acs[g][PM_W-1];
  end

  // ---------------------------------------------------------------------------
  // Normalisation: once every metric has its MSB set, drop the MSB from all.
  // Relative order is unchanged, so the argmin below is unaffected.
  // ---------------------------------------------------------------------------
  assign w_all_msb = &w_msb;

  for (genvar g = 0; g < NUM_STATES; g++) begin : g_norm
    assign w_pm_norm[g] = w_all_msb ? {1'b0, w_pm_acs[g][PM_W-2:0]}
                                    : w_pm_acs[g];
  end

  // ---------------------------------------------------------------------------
  // Argmin tree. Pairs are compared strictly, and the low pair only loses on a
  // strictly smaller high-pair metric, so ties go to the lowest state index.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_lo   = (w_pm_norm[1] < w_pm_norm[0]) ? 2'd1 : 2'd0;
    w_hi   = (w_pm_norm[3] < w_pm_norm[2]) ? 2'd3 : 2'd2;
    w_best = (w_pm_norm[w_hi] < w_pm_norm[w_lo]) ? w_hi : w_lo;
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < NUM_STATES; s++) begin
        r_pm[s] <= (s == 0) ? '0 : PM_INIT;
      end
      r_surv  <= '0;
      r_cnt   <= '0;
      b_out   <= 1'b0;
      b_valid <= 1'b0;
      best_pm <= '0;
    end else begin
      b_valid <= 1'b0;
      if (c_valid) begin
        r_pm <= w_pm_norm;
        for (int s = 0; s < NUM_STATES; s++) begin
          r_surv[s] <= w_surv_full[s][TB_DEPTH-2:0];
        end
        if (r_cnt != CNT_SAT) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
        // r_cnt equals min(k, TB_DEPTH) for the symbol k being accepted.
        b_valid <= (r_cnt >= CNT_OUT);
        b_out   <= w_surv_full[w_best][TB_DEPTH-1];
        best_pm <= w_pm_norm[w_best];
      end
    end
  end

endmodule
